// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes and FSM state encoding for the keypad entry controller
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        CHECK = 3'd2,
        OPEN  = 3'd3,
        LOCK  = 3'd4,
        SET   = 3'd5
    } state_t;

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// rtl/keypad_entry_ctrl_if.sv - key input, set request and status outputs of the entry controller
interface keypad_entry_ctrl_if;

    logic [3:0] key_inp;
    logic       set_req;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] digit_cnt;
    logic       unlock;
    logic       error;
    logic       locked;
    logic       set_mode;

    modport master (
        output key_inp, set_req,
        input  key_valid, key_code, digit_cnt, unlock, error, locked, set_mode
    );

    modport slave (
        input  key_inp, set_req,
        output key_valid, key_code, digit_cnt, unlock, error, locked, set_mode
    );

endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - per-window key sampling and press/release debounce into single key events
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN     = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_inp,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int WW = (SCAN > 1) ? $clog2(SCAN) : 1;
    localparam int RW = $clog2(DEBOUNCE + 1);

    logic [WW-1:0] win_cnt;
    logic [3:0]    cap;
    logic          cap_vld;
    logic [3:0]    res_q;
    logic          res_stb;
    logic [3:0]    last_res;
    logic [RW-1:0] run;
    logic          released;

    logic          hit;
    logic          win_end;
    logic [3:0]    win_res;
    logic [RW-1:0] run_n;
    logic          stable;

    always_comb begin
        hit     = key_inp < KEY_NONE;
        win_end = win_cnt == WW'(SCAN - 1);
        win_res = cap_vld ? cap : (hit ? key_inp : KEY_NONE);
        if (res_q != last_res)
            run_n = RW'(1);
        else if (run == RW'(DEBOUNCE))
            run_n = run;
        else
            run_n = run + RW'(1);
        stable = res_stb && (run_n == RW'(DEBOUNCE));
    end

    // Window result is registered first, so the run update lands one cycle after the window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            cap       <= KEY_NONE;
            cap_vld   <= 1'b0;
            res_q     <= KEY_NONE;
            res_stb   <= 1'b0;
            last_res  <= KEY_NONE;
            run       <= '0;
            released  <= 1'b1;
            key_valid <= 1'b0;
            key_code  <= KEY_NONE;
        end else begin
            key_valid <= 1'b0;
            res_stb   <= win_end;
            if (win_end) begin
                win_cnt <= '0;
                cap_vld <= 1'b0;
                res_q   <= win_res;
            end else begin
                win_cnt <= win_cnt + WW'(1);
                if (!cap_vld && hit) begin
                    cap     <= key_inp;
                    cap_vld <= 1'b1;
                end
            end
            if (res_stb) begin
                last_res <= res_q;
                run      <= run_n;
                if (stable) begin
                    if (res_q == KEY_NONE) begin
                        released <= 1'b1;
                    end else if (released) begin
                        key_valid <= 1'b1;
                        key_code  <= res_q;
                        released  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - code entry FSM with password check, lockout and password change
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int          DIGITS   = 4,
    parameter int          SCAN     = 4,
    parameter int          DEBOUNCE = 3,
    parameter int          MAX_FAIL = 3,
    parameter int          LOCK_CYC = 1000,
    parameter int          OPEN_CYC = 200,
    parameter logic [4*DIGITS-1:0] INIT_PW = 16'h1234
) (
    input logic                clk,
    input logic                rst,
    keypad_entry_ctrl_if.slave bus
);

    localparam int PW_W = 4 * DIGITS;
    localparam int DW   = $clog2(DIGITS + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (LOCK_CYC > OPEN_CYC) ? LOCK_CYC : OPEN_CYC;
    localparam int TW   = $clog2(TMAX);

    logic       kv;
    logic [3:0] kc;

    keypad_debounce #(.SCAN(SCAN), .DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_inp   (bus.key_inp),
        .key_valid (kv),
        .key_code  (kc)
    );

    state_t          state, state_n;
    logic [PW_W-1:0] entry, entry_n, pw, pw_n;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [FW-1:0]   fail, fail_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic            err_q, err_n;

    logic            is_digit, is_star, is_hash, full;
    logic [PW_W-1:0] entry_shift;

    always_comb begin
        is_digit    = kv && (kc <= 4'd9);
        is_star     = kv && (kc == KEY_STAR);
        is_hash     = kv && (kc == KEY_HASH);
        full        = dcnt == DW'(DIGITS);
        entry_shift = PW_W'(entry << 4) | PW_W'(kc);

        state_n = state;
        entry_n = entry;
        dcnt_n  = dcnt;
        pw_n    = pw;
        fail_n  = fail;
        tmr_n   = '0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.set_req) begin
                    state_n = SET;
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (is_digit) begin
                    state_n = ENTRY;
                    entry_n = PW_W'(kc);
                    dcnt_n  = DW'(1);
                end
            end
            ENTRY, SET: begin
                if (is_digit) begin
                    if (!full) begin
                        entry_n = entry_shift;
                        dcnt_n  = dcnt + DW'(1);
                    end
                end else if (is_star) begin
                    state_n = IDLE;
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (is_hash) begin
                    if (state == ENTRY) begin
                        state_n = CHECK;
                    end else begin
                        // A short entry in set mode leaves the old password in place.
                        if (full) pw_n = entry;
                        else      err_n = 1'b1;
                        state_n = IDLE;
                        entry_n = '0;
                        dcnt_n  = '0;
                    end
                end
            end
            CHECK: begin
                entry_n = '0;
                dcnt_n  = '0;
                if (full && entry == pw) begin
                    state_n = OPEN;
                    fail_n  = '0;
                end else begin
                    err_n   = 1'b1;
                    fail_n  = fail + FW'(1);
                    state_n = (fail == FW'(MAX_FAIL - 1)) ? LOCK : IDLE;
                end
            end
            OPEN: begin
                if (tmr == TW'(OPEN_CYC - 1)) state_n = IDLE;
                else                          tmr_n   = tmr + TW'(1);
            end
            LOCK: begin
                if (tmr == TW'(LOCK_CYC - 1)) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            entry <= '0;
            dcnt  <= '0;
            pw    <= INIT_PW;
            fail  <= '0;
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            entry <= entry_n;
            dcnt  <= dcnt_n;
            pw    <= pw_n;
            fail  <= fail_n;
            tmr   <= tmr_n;
            err_q <= err_n;
        end
    end

    assign bus.key_valid = kv;
    assign bus.key_code  = kc;
    assign bus.digit_cnt = 3'(dcnt);
    assign bus.unlock    = state == OPEN;
    assign bus.locked    = state == LOCK;
    assign bus.set_mode  = state == SET;
    assign bus.error     = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - scoreboard bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   phase = 0;
    int   kv_count = 0;

    int key_q[$];
    int err_q[$];
    int unl_q[$];
    int lck_q[$];

    keypad_entry_ctrl_if ifc();

    keypad_entry_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) phase <= 0;
        else     phase <= (phase == 3) ? 0 : phase + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int  ulen = 0, llen = 0;
    bit  prev_err = 0, prev_unl = 0, prev_lck = 0;

    always @(negedge clk) begin
        if (rst) begin
            ulen = 0; llen = 0;
            prev_err = 0; prev_unl = 0; prev_lck = 0;
        end else begin
            if (ifc.key_valid) begin
                kv_count++;
                if (key_q.size() == 0) chk("key_event_unexpected", int'(ifc.key_code), -1);
                else chk("key_code", int'(ifc.key_code), key_q.pop_front());
            end
            if (ifc.error) begin
                if (prev_err) chk("error_width", 2, 1);
                else if (err_q.size() == 0) chk("error_unexpected", 1, 0);
                else chk("error_pulse", 1, err_q.pop_front());
            end
            if (ifc.unlock) ulen++;
            else if (prev_unl) begin
                if (unl_q.size() == 0) chk("unlock_unexpected", ulen, 0);
                else chk("unlock_len", ulen, unl_q.pop_front());
                ulen = 0;
            end
            if (ifc.locked) llen++;
            else if (prev_lck) begin
                if (lck_q.size() == 0) chk("locked_unexpected", llen, 0);
                else chk("locked_len", llen, lck_q.pop_front());
                llen = 0;
            end
            prev_err = ifc.error;
            prev_unl = ifc.unlock;
            prev_lck = ifc.locked;
        end
    end

    task automatic wait_phase0();
        @(negedge clk);
        while (phase != 0) @(negedge clk);
    endtask

    task automatic drive(input int v, input int n);
        repeat (n) begin
            ifc.key_inp = 4'(v);
            @(negedge clk);
        end
    endtask

    task automatic press(input int k);
        wait_phase0();
        key_q.push_back(k);
        drive(k, 16);
        drive(12, 16);
    endtask

    task automatic seq(input string s);
        int k;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "*")      k = 10;
            else if (s[i] == "#") k = 11;
            else                  k = int'(s[i]) - 48;
            press(k);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ifc.unlock || ifc.locked) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_in_budget", int'(n < 3000), 1);
        chk("digit_cnt_after_idle", int'(ifc.digit_cnt), 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_key_valid", int'(ifc.key_valid), 0);
        chk("rst_key_code", int'(ifc.key_code), 12);
        chk("rst_digit_cnt", int'(ifc.digit_cnt), 0);
        chk("rst_unlock", int'(ifc.unlock), 0);
        chk("rst_error", int'(ifc.error), 0);
        chk("rst_locked", int'(ifc.locked), 0);
        chk("rst_set_mode", int'(ifc.set_mode), 0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int kv0;
        ifc.key_inp = 4'd12;
        ifc.set_req = 1'b0;
        @(negedge clk);
        reset_pulse();
        drive(12, 8);

        // Sparse press: key present one cycle in four for three windows.
        wait_phase0();
        key_q.push_back(1);
        lat = -1;
        ifc.key_inp = 4'd1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifc.key_valid && lat < 0) lat = i;
            ifc.key_inp = (i < 12 && (i % 4) == 0) ? 4'd1 : 4'd12;
        end
        chk("press_latency", lat, 13);
        drive(12, 16);
        chk("digit_cnt_first", int'(ifc.digit_cnt), 1);

        // Held key for 100 windows gives one event.
        wait_phase0();
        kv0 = kv_count;
        key_q.push_back(2);
        drive(2, 400);
        drive(12, 16);
        chk("held_key_events", kv_count - kv0, 1);
        chk("digit_cnt_held", int'(ifc.digit_cnt), 2);
        seq("*");
        chk("digit_cnt_star", int'(ifc.digit_cnt), 0);

        // Two codes in a window: the first one wins.
        wait_phase0();
        key_q.push_back(3);
        repeat (4) begin
            drive(3, 1);
            drive(5, 2);
            drive(12, 1);
        end
        drive(12, 16);
        seq("*");

        unl_q.push_back(200);
        seq("1234#");
        wait_idle();

        err_q.push_back(1);
        seq("123#");
        chk("no_unlock_short", int'(ifc.unlock), 0);
        err_q.push_back(1);
        seq("1235#");
        err_q.push_back(1);
        lck_q.push_back(1000);
        seq("9#");
        chk("locked_after_fails", int'(ifc.locked), 1);
        wait_idle();
        unl_q.push_back(200);
        seq("1234#");
        wait_idle();

        seq("56");
        chk("digit_cnt_56", int'(ifc.digit_cnt), 2);
        seq("*");
        chk("digit_cnt_abort", int'(ifc.digit_cnt), 0);
        unl_q.push_back(200);
        seq("1234#");
        wait_idle();

        ifc.set_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("set_mode_on", int'(ifc.set_mode), 1);
        ifc.set_req = 1'b0;
        seq("9876#");
        chk("set_mode_off", int'(ifc.set_mode), 0);
        err_q.push_back(1);
        seq("1234#");
        unl_q.push_back(200);
        seq("9876#");
        wait_idle();

        ifc.set_req = 1'b1;
        repeat (3) @(negedge clk);
        ifc.set_req = 1'b0;
        err_q.push_back(1);
        seq("98#");
        seq("987654");
        chk("digit_cnt_saturate", int'(ifc.digit_cnt), 4);
        unl_q.push_back(200);
        seq("#");
        wait_idle();

        seq("12");
        chk("digit_cnt_before_rst", int'(ifc.digit_cnt), 2);
        reset_pulse();
        unl_q.push_back(200);
        seq("1234#");
        wait_idle();

        err_q.push_back(1);
        seq("1#");
        err_q.push_back(1);
        seq("2#");
        err_q.push_back(1);
        seq("3#");
        chk("locked_before_rst", int'(ifc.locked), 1);
        repeat (100) @(negedge clk);
        reset_pulse();
        unl_q.push_back(200);
        seq("1234#");
        wait_idle();

        drive(12, 8);
        chk("key_q_drained", key_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("unl_q_drained", unl_q.size(), 0);
        chk("lck_q_drained", lck_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
